// File: rtl/dht11_sensor_responder_if.sv
// Bus bundle between a DHT11 host-side driver and the sensor responder.
// Carries the enable, payload bytes, data-line level and status pulses.
`timescale 1ns/1ps
interface dht11_sensor_responder_if;
    logic       en;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       dht_in;
    logic       dht_drive_low;
    logic       busy;
    logic       frame_done;
    logic       short_start;

    modport master (
        output en,
        output hum_int,
        output hum_dec,
        output temp_int,
        output temp_dec,
        output dht_in,
        input  dht_drive_low,
        input  busy,
        input  frame_done,
        input  short_start
    );

    modport slave (
        input  en,
        input  hum_int,
        input  hum_dec,
        input  temp_int,
        input  temp_dec,
        input  dht_in,
        output dht_drive_low,
        output busy,
        output frame_done,
        output short_start
    );
endinterface

// File: rtl/dht11_sensor_responder.sv
// DHT11 sensor-side emulator: waits for a host start pulse, then
// answers with the response preamble and a 40-bit MSB-first frame.
`timescale 1ns/1ps
module dht11_sensor_responder #(
    parameter int unsigned START_LOW_MIN = 1800000,
    parameter int unsigned RESP_WAIT     = 3000,
    parameter int unsigned RESP_LOW      = 8000,
    parameter int unsigned RESP_HIGH     = 8000,
    parameter int unsigned BIT_LOW       = 5000,
    parameter int unsigned BIT0_HIGH     = 2700,
    parameter int unsigned BIT1_HIGH     = 7000
) (
    input  logic                      clk,
    input  logic                      rst,
    dht11_sensor_responder_if.slave   bus
);
    // Sum of all limits is a cheap upper bound on any single phase length.
    localparam int unsigned MAXP = START_LOW_MIN + RESP_WAIT + RESP_LOW
                                 + RESP_HIGH + BIT_LOW + BIT0_HIGH
                                 + BIT1_HIGH;
    localparam int unsigned CW = $clog2(MAXP + 1);

    typedef enum logic [3:0] {
        IDLE,
        HOST_LOW,
        WAIT_RELEASE,
        RESP_DELAY,
        RESP_LO,
        RESP_HI,
        BIT_LO,
        BIT_HI,
        END_LO
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [1:0]    sync_q;
    logic          sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;
    logic          phase_done;
    logic [39:0]   sreg;
    logic [5:0]    bit_idx;
    logic [7:0]    csum;
    logic          latch;
    logic          shift;
    logic          drive_n;
    logic          short_n;
    logic          done_n;
    logic          drive_q;
    logic          busy_q;
    logic          done_q;
    logic          short_q;

    assign sync = sync_q[1];
    assign csum = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;

    always_comb begin
        lim = '0;
        unique case (state)
            HOST_LOW:   lim = CW'(START_LOW_MIN - 1);
            RESP_DELAY: lim = CW'(RESP_WAIT - 1);
            RESP_LO:    lim = CW'(RESP_LOW - 1);
            RESP_HI:    lim = CW'(RESP_HIGH - 1);
            BIT_LO:     lim = CW'(BIT_LOW - 1);
            BIT_HI:     lim = sreg[39] ? CW'(BIT1_HIGH - 1)
                                       : CW'(BIT0_HIGH - 1);
            END_LO:     lim = CW'(BIT_LOW - 1);
            default:    lim = '0;
        endcase
    end

    assign phase_done = (cnt == lim);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.en && !sync) state_n = HOST_LOW;
            end
            HOST_LOW: begin
                if (sync)            state_n = IDLE;
                else if (phase_done) state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (sync) state_n = RESP_DELAY;
            end
            RESP_DELAY: begin
                if (phase_done) state_n = RESP_LO;
            end
            RESP_LO: begin
                if (phase_done) state_n = RESP_HI;
            end
            RESP_HI: begin
                if (phase_done) state_n = BIT_LO;
            end
            BIT_LO: begin
                if (phase_done) state_n = BIT_HI;
            end
            BIT_HI: begin
                if (phase_done)
                    state_n = (bit_idx == 6'd39) ? END_LO : BIT_LO;
            end
            END_LO: begin
                if (phase_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign latch   = (state == WAIT_RELEASE) && sync;
    assign shift   = (state == BIT_HI) && phase_done;
    assign short_n = (state == HOST_LOW) && sync;
    assign done_n  = (state == END_LO) && phase_done;
    assign drive_n = (state_n == RESP_LO) || (state_n == BIT_LO)
                  || (state_n == END_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.dht_in};
        end
    end

    // Every state entry restarts the phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else if (latch) begin
            sreg    <= {bus.hum_int, bus.hum_dec,
                        bus.temp_int, bus.temp_dec, csum};
            bit_idx <= '0;
        end else if (shift) begin
            sreg    <= {sreg[38:0], 1'b0};
            bit_idx <= bit_idx + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            drive_q <= drive_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= done_n;
            short_q <= short_n;
        end
    end

    assign bus.dht_drive_low = drive_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
    assign bus.short_start   = short_q;
endmodule

// File: tb/tb_dht11_sensor_responder.sv
// Directed bench for the DHT11 responder: open-drain line model plus
// a width-measuring frame decoder driven from one initial block.
`timescale 1ns/1ps
module tb_dht11_sensor_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic host_pull = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   fd_cnt = 0;
    int   ss_cnt = 0;
    int   dl_cnt = 0;
    int   busy_cnt = 0;

    dht11_sensor_responder_if bus ();

    // Wired-AND line: either side pulling low wins.
    assign bus.dht_in = !(host_pull || bus.dht_drive_low);

    dht11_sensor_responder #(
        .START_LOW_MIN (100),
        .RESP_WAIT     (30),
        .RESP_LOW      (80),
        .RESP_HIGH     (80),
        .BIT_LOW       (50),
        .BIT0_HIGH     (27),
        .BIT1_HIGH     (70)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_done)    fd_cnt++;
        if (bus.short_start)   ss_cnt++;
        if (bus.dht_drive_low) dl_cnt++;
        if (bus.busy)          busy_cnt++;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bytes(input logic [31:0] v);
        bus.hum_int  = v[31:24];
        bus.hum_dec  = v[23:16];
        bus.temp_int = v[15:8];
        bus.temp_dec = v[7:0];
    endtask

    task automatic host_start(input int len);
        @(negedge clk);
        host_pull = 1'b1;
        repeat (len) @(negedge clk);
        host_pull = 1'b0;
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (bus.dht_drive_low === lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic read_frame(input logic [39:0] exp, input int chg_bit,
                              input logic [31:0] chg_val,
                              input int abort_bit);
        int          n;
        int          fd0;
        logic [39:0] got;
        logic        bad;
        fd0 = fd_cnt;
        host_start(150);
        // Release-to-response includes the 2-flop sync and one state step.
        measure(1'b0, n);
        check("resp_delay_window", 32'(n >= 30 && n <= 34), 32'd1);
        measure(1'b1, n);
        check("resp_low", n, 80);
        measure(1'b0, n);
        check("resp_high", n, 80);
        bad = 1'b0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            if (i == chg_bit) set_bytes(chg_val);
            if (i == abort_bit) begin
                repeat (10) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("abort_drive_low", bus.dht_drive_low, 0);
                check("abort_busy", bus.busy, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (200) @(negedge clk);
                check("abort_no_frame_done", fd_cnt - fd0, 0);
                return;
            end
            measure(1'b1, n);
            if (n != 50) bad = 1'b1;
            measure(1'b0, n);
            if (n != 27 && n != 70) bad = 1'b1;
            got = {got[38:0], (n > 48)};
        end
        check("bit_timing", bad, 0);
        measure(1'b1, n);
        check("end_low", n, 50);
        check("frame_done_pulse", bus.frame_done, 1);
        check("busy_falls", bus.busy, 0);
        check("hum_int", got[39:32], exp[39:32]);
        check("hum_dec", got[31:24], exp[31:24]);
        check("temp_int", got[23:16], exp[23:16]);
        check("temp_dec", got[15:8], exp[15:8]);
        check("checksum", got[7:0], exp[7:0]);
        settle();
        check("one_frame_done", fd_cnt - fd0, 1);
    endtask

    initial begin
        int ss0;
        int dl0;
        int bz0;
        bus.en = 1'b1;
        set_bytes(32'h0);

        #1 rst = 1'b1;
        #2;
        check("rst_drive_low", bus.dht_drive_low, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_short_start", bus.short_start, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        set_bytes(32'h37001900);
        read_frame(40'h3700190050, -1, 32'h0, -1);

        set_bytes(32'hFFFF0102);
        read_frame(40'hFFFF010201, -1, 32'h0, -1);

        ss0 = ss_cnt;
        dl0 = dl_cnt;
        host_start(60);
        repeat (20) @(negedge clk);
        check("short_start_once", ss_cnt - ss0, 1);
        check("short_no_drive", dl_cnt - dl0, 0);
        check("short_idle", bus.busy, 0);

        set_bytes(32'h37001900);
        read_frame(40'h3700190050, 10, 32'hAAAAAAAA, -1);
        settle();
        read_frame(40'hAAAAAAAAA8, -1, 32'h0, -1);

        set_bytes(32'h37001900);
        read_frame(40'h3700190050, -1, 32'h0, 5);
        settle();
        read_frame(40'h3700190050, -1, 32'h0, -1);

        bus.en = 1'b0;
        ss0 = ss_cnt;
        dl0 = dl_cnt;
        bz0 = busy_cnt;
        host_start(150);
        repeat (200) @(negedge clk);
        check("en0_no_drive", dl_cnt - dl0, 0);
        check("en0_no_short", ss_cnt - ss0, 0);
        check("en0_no_busy", busy_cnt - bz0, 0);
        bus.en = 1'b1;
        settle();
        read_frame(40'h3700190050, -1, 32'h0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
